// File: rtl/fighter_pkg.sv
// Shared fighter constants and types, used by both the Akuma and Ryu knockback
// controllers.
//   kb_state_t : knockback FSM state (IDLE / PUSH / STUN)
//   hit_str_t  : 2-bit hit strength (0 light, 1 medium, 2/3 heavy)
//   V_*        : initial push velocities in px/frame
//   STUN_*     : stun frames that follow the push
//   v_init()   : initial push velocity for a strength, halved when blocked
//   stun_init(): stun length for a strength, or block stun when blocked
package fighter_pkg;

  typedef enum logic [1:0] {IDLE, PUSH, STUN} kb_state_t;
  typedef logic [1:0] hit_str_t;

  localparam logic [3:0] V_LIGHT    = 4'd4;
  localparam logic [3:0] V_MED      = 4'd6;
  localparam logic [3:0] V_HEAVY    = 4'd8;
  localparam logic [4:0] STUN_LIGHT = 5'd6;
  localparam logic [4:0] STUN_MED   = 5'd10;
  localparam logic [4:0] STUN_HEAVY = 5'd16;
  localparam logic [4:0] BLOCK_STUN = 5'd4;

  function automatic logic [3:0] v_init(hit_str_t str, logic blocking);
    logic [3:0] v;
    case (str)
      2'd0:    v = V_LIGHT;
      2'd1:    v = V_MED;
      default: v = V_HEAVY;
    endcase
    return blocking ? (v >> 1) : v;
  endfunction

  function automatic logic [4:0] stun_init(hit_str_t str, logic blocking);
    logic [4:0] s;
    case (str)
      2'd0:    s = STUN_LIGHT;
      2'd1:    s = STUN_MED;
      default: s = STUN_HEAVY;
    endcase
    return blocking ? BLOCK_STUN : s;
  endfunction

endpackage

// File: rtl/kb_wall_clamp.sv
// Combinational wall clamp for the knockback push.
//   v        : requested push this frame (px)
//   akuma_x  : current Akuma X position
//   kb       : push limited so the sprite's right edge stops at the screen
//              bound; 0 once the sprite is at or past the wall
module kb_wall_clamp #(
  parameter int BOUND_X_MAX = 629,
  parameter int WALL_OFFSET = 125
) (
  input  logic [3:0]         v,
  input  logic [9:0]         akuma_x,
  output logic signed [31:0] kb
);

  logic signed [31:0] allowed;
  logic signed [31:0] v_s;

  always_comb begin
    allowed = BOUND_X_MAX - WALL_OFFSET - $signed({22'd0, akuma_x});
    v_s     = $signed({28'd0, v});
    if (allowed <= 0)
      kb = '0;
    else if (v_s < allowed)
      kb = v_s;
    else
      kb = allowed;
  end

endmodule

// File: rtl/akuma_knockback_ctrl.sv
// Akuma knockback controller: turns a one-frame hit pulse into a decaying
// horizontal push followed by a stun window, with blocking, wall clamping and
// combo reloads.
//   frame_clk       : frame clock
//   Reset           : synchronous active-low reset
//   GamePlaying     : high advances, low freezes all state
//   HitValid        : one-frame hit pulse
//   HitStrength     : 0 light, 1 medium, 2/3 heavy
//   Blocking        : Akuma is holding back when the hit lands
//   AkumaX          : current Akuma X position
//   Akuma_Knockback : displacement added to AkumaX this frame, never negative
//   AkumaHitStun    : in an unblocked push or stun
//   AkumaBlockStun  : in a blocked push or stun
//   ComboCount      : hits since leaving IDLE, saturating at 15
module akuma_knockback_ctrl
  import fighter_pkg::*;
#(
  parameter int Bound_X_Max = 629,
  parameter int WALL_OFFSET = 125
) (
  input  logic               frame_clk,
  input  logic               Reset,
  input  logic               GamePlaying,
  input  logic               HitValid,
  input  logic [1:0]         HitStrength,
  input  logic               Blocking,
  input  logic [9:0]         AkumaX,
  output logic signed [31:0] Akuma_Knockback,
  output logic               AkumaHitStun,
  output logic               AkumaBlockStun,
  output logic [3:0]         ComboCount
);

  kb_state_t          state, state_n;
  logic [3:0]         vel, vel_n;
  logic [4:0]         stun_cnt, stun_n;
  logic               blk, blk_n;
  logic [3:0]         combo_n;
  logic signed [31:0] kb_n;
  logic               hs_n, bs_n;

  logic [3:0]         v0;
  logic [3:0]         clamp_v;
  logic signed [31:0] clamp_kb;

  assign v0 = v_init(HitStrength, Blocking);

  // One clamp serves both the fresh hit and the ongoing decay; a hit always
  // takes priority so its velocity is what gets clamped on that edge.
  assign clamp_v = HitValid ? v0 : vel;

  kb_wall_clamp #(
    .BOUND_X_MAX(Bound_X_Max),
    .WALL_OFFSET(WALL_OFFSET)
  ) u_clamp (
    .v      (clamp_v),
    .akuma_x(AkumaX),
    .kb     (clamp_kb)
  );

  always_ff @(posedge frame_clk) begin
    if (!Reset) begin
      state           <= IDLE;
      vel             <= '0;
      stun_cnt        <= '0;
      blk             <= 1'b0;
      ComboCount      <= '0;
      Akuma_Knockback <= '0;
      AkumaHitStun    <= 1'b0;
      AkumaBlockStun  <= 1'b0;
    end else begin
      state           <= state_n;
      vel             <= vel_n;
      stun_cnt        <= stun_n;
      blk             <= blk_n;
      ComboCount      <= combo_n;
      Akuma_Knockback <= kb_n;
      AkumaHitStun    <= hs_n;
      AkumaBlockStun  <= bs_n;
    end
  end

  always_comb begin
    state_n = state;
    vel_n   = vel;
    stun_n  = stun_cnt;
    blk_n   = blk;
    combo_n = ComboCount;
    kb_n    = '0;

    if (GamePlaying) begin
      if (HitValid) begin
        state_n = PUSH;
        vel_n   = v0 - 4'd1;
        stun_n  = stun_init(HitStrength, Blocking);
        blk_n   = Blocking;
        combo_n = (ComboCount == 4'd15) ? 4'd15 : ComboCount + 4'd1;
        kb_n    = clamp_kb;
      end else begin
        case (state)
          PUSH: begin
            // vel decays even while the clamp pins the output at 0
            if (vel != 4'd0) begin
              kb_n  = clamp_kb;
              vel_n = vel - 4'd1;
            end else begin
              state_n = STUN;
            end
          end
          STUN: begin
            if (stun_cnt > 5'd1) begin
              stun_n = stun_cnt - 5'd1;
            end else begin
              state_n = IDLE;
              combo_n = '0;
            end
          end
          default: ;
        endcase
      end
    end

    // Flags follow the registered state so they line up with the knockback.
    hs_n = (state_n != IDLE) && !blk_n;
    bs_n = (state_n != IDLE) && blk_n;
  end

endmodule

// File: tb/tb_akuma_knockback_ctrl.sv
// Self-checking bench for akuma_knockback_ctrl. Each frame's expected outputs
// are queued as the stimulus is applied and compared after the edge.
module tb_akuma_knockback_ctrl;

  logic               frame_clk = 1'b0;
  logic               Reset = 1'b0;
  logic               GamePlaying = 1'b1;
  logic               HitValid = 1'b0;
  logic [1:0]         HitStrength = 2'd0;
  logic               Blocking = 1'b0;
  logic [9:0]         AkumaX = 10'd300;
  logic signed [31:0] Akuma_Knockback;
  logic               AkumaHitStun;
  logic               AkumaBlockStun;
  logic [3:0]         ComboCount;

  int vectors = 0;
  int miscompares = 0;
  logic [37:0] exp_q[$];

  akuma_knockback_ctrl dut (
    .frame_clk      (frame_clk),
    .Reset          (Reset),
    .GamePlaying    (GamePlaying),
    .HitValid       (HitValid),
    .HitStrength    (HitStrength),
    .Blocking       (Blocking),
    .AkumaX         (AkumaX),
    .Akuma_Knockback(Akuma_Knockback),
    .AkumaHitStun   (AkumaHitStun),
    .AkumaBlockStun (AkumaBlockStun),
    .ComboCount     (ComboCount)
  );

  always #5 frame_clk = ~frame_clk;

  // Queue the expectation for this frame, take one edge, then compare.
  task automatic step(input string tag, input int ekb, input logic ehs,
                      input logic ebs, input logic [3:0] ecc);
    logic [37:0] e, a;
    e = {ekb[31:0], ehs, ebs, ecc};
    exp_q.push_back(e);
    @(posedge frame_clk);
    #1;
    HitValid = 1'b0;
    a = {Akuma_Knockback, AkumaHitStun, AkumaBlockStun, ComboCount};
    e = exp_q.pop_front();
    vectors++;
    if (a !== e) begin
      miscompares++;
      $display("FAIL %s: got kb=%0d hs=%b bs=%b cc=%0d, expected kb=%0d hs=%b bs=%b cc=%0d",
               tag, $signed(a[37:6]), a[5], a[4], a[3:0],
               $signed(e[37:6]), e[5], e[4], e[3:0]);
    end
  endtask

  task automatic hit(input logic [1:0] s, input logic b);
    HitValid    = 1'b1;
    HitStrength = s;
    Blocking    = b;
  endtask

  task automatic do_reset();
    Reset = 1'b0;
    step("reset", 0, 0, 0, 0);
    Reset = 1'b1;
  endtask

  task automatic test_reset();
    Reset = 1'b0;
    step("reset_state", 0, 0, 0, 0);
    step("reset_state2", 0, 0, 0, 0);
    Reset = 1'b1;
    step("idle_no_hit", 0, 0, 0, 0);
  endtask

  task automatic test_heavy();
    AkumaX = 10'd300;
    hit(2'd2, 1'b0);
    step("heavy_first", 8, 1, 0, 1);
    for (int v = 7; v >= 1; v--) step("heavy_decay", v, 1, 0, 1);
    for (int i = 0; i < 16; i++) step("heavy_stun", 0, 1, 0, 1);
    step("heavy_idle", 0, 0, 0, 0);
    step("heavy_idle2", 0, 0, 0, 0);
  endtask

  task automatic test_blocked();
    hit(2'd1, 1'b1);
    step("block_first", 3, 0, 1, 1);
    step("block_decay", 2, 0, 1, 1);
    step("block_decay", 1, 0, 1, 1);
    for (int i = 0; i < 4; i++) step("block_stun", 0, 0, 1, 1);
    step("block_idle", 0, 0, 0, 0);
    Blocking = 1'b0;
  endtask

  task automatic test_wall();
    AkumaX = 10'd500;
    hit(2'd2, 1'b0);
    step("wall_first", 4, 1, 0, 1);
    for (int i = 0; i < 4; i++) step("wall_pinned", 4, 1, 0, 1);
    step("wall_tail", 3, 1, 0, 1);
    step("wall_tail", 2, 1, 0, 1);
    step("wall_tail", 1, 1, 0, 1);
    do_reset();
    // at the wall the output is 0 but vel keeps decaying
    AkumaX = 10'd504;
    hit(2'd2, 1'b0);
    step("wall_zero_first", 0, 1, 0, 1);
    for (int i = 0; i < 3; i++) step("wall_zero", 0, 1, 0, 1);
    AkumaX = 10'd300;
    for (int v = 4; v >= 1; v--) step("wall_release", v, 1, 0, 1);
    step("wall_release_stun", 0, 1, 0, 1);
    do_reset();
    AkumaX = 10'd700;
    hit(2'd0, 1'b0);
    step("wall_past", 0, 1, 0, 1);
    do_reset();
    AkumaX = 10'd300;
  endtask

  task automatic test_combo();
    hit(2'd0, 1'b0);
    step("combo_light", 4, 1, 0, 1);
    for (int v = 3; v >= 1; v--) step("combo_light_decay", v, 1, 0, 1);
    step("combo_stun1", 0, 1, 0, 1);
    step("combo_stun2", 0, 1, 0, 1);
    hit(2'd2, 1'b0);
    step("combo_reload", 8, 1, 0, 2);
    step("combo_reload_decay", 7, 1, 0, 2);
    for (int i = 1; i <= 20; i++) begin
      hit(2'd3, 1'b0);
      step("combo_sat", 8, 1, 0, (2 + i > 15) ? 4'd15 : 4'(2 + i));
    end
    do_reset();
  endtask

  task automatic test_freeze();
    hit(2'd2, 1'b0);
    step("freeze_hit", 8, 1, 0, 1);
    step("freeze_pre", 7, 1, 0, 1);
    step("freeze_pre", 6, 1, 0, 1);
    GamePlaying = 1'b0;
    for (int i = 0; i < 5; i++) begin
      if (i == 2) hit(2'd2, 1'b0);
      step("freeze_hold", 0, 1, 0, 1);
    end
    GamePlaying = 1'b1;
    for (int v = 5; v >= 1; v--) step("freeze_resume", v, 1, 0, 1);
    step("freeze_stun", 0, 1, 0, 1);
    do_reset();
  endtask

  task automatic test_reset_mid();
    hit(2'd2, 1'b0);
    step("rmid_hit", 8, 1, 0, 1);
    step("rmid_decay", 7, 1, 0, 1);
    Reset = 1'b0;
    hit(2'd2, 1'b0);
    step("rmid_reset_wins", 0, 0, 0, 0);
    Reset = 1'b1;
    step("rmid_after", 0, 0, 0, 0);
  endtask

  initial begin
    test_reset();
    test_heavy();
    test_blocked();
    test_wall();
    test_combo();
    test_freeze();
    test_reset_mid();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule

// File: doc/akuma_knockback_ctrl.md
Name: akuma_knockback_ctrl

Overview:
- Generates the per-frame horizontal knockback displacement (Akuma_Knockback) consumed by the Akuma movement block, plus the hit-stun and block-stun status flags.
- Sits directly upstream of the movement block and downstream of hit detection.
- Converts a one-frame hit event into a decaying push followed by a stun window.
- Handles blocking, wall clamping and re-hits (combos).

Parameters:
- Bound_X_Max, 629, rightmost screen X.
- WALL_OFFSET, 125, offset from AkumaX to the sprite's right edge.
- V_LIGHT, 4, initial push velocity for a light hit (px/frame).
- V_MED, 6, initial push velocity for a medium hit.
- V_HEAVY, 8, initial push velocity for a heavy hit.
- STUN_LIGHT, 6, stun frames after the push, light hit.
- STUN_MED, 10, stun frames after the push, medium hit.
- STUN_HEAVY, 16, stun frames after the push, heavy hit.
- BLOCK_STUN, 4, stun frames after a blocked push.

Ports:
- frame_clk  in  1  frame clock; the block's only clock.
- Reset  in  1  synchronous, active-low reset.
- GamePlaying  in  1  high = advance; low = freeze.
- HitValid  in  1  one-frame pulse: Akuma was struck.
- HitStrength  in  2  0 = light, 1 = medium, 2 = heavy; 3 is treated as heavy.
- Blocking  in  1  Akuma is holding back (right) when the hit lands.
- AkumaX  in  10  current Akuma X position.
- Akuma_Knockback  out  int (32 signed)  displacement added to AkumaX this frame; always >= 0.
- AkumaHitStun  out  1  in an unblocked push or stun.
- AkumaBlockStun  out  1  in a blocked push or stun.
- ComboCount  out  4  hits landed since leaving IDLE; saturates at 15.

Behaviour:
- State machine states: IDLE, PUSH, STUN. Internal registers: vel (4b), stun_cnt (5b), blk (1b).
- Reset (Reset == 0 at an edge):
  - state = IDLE.
  - Akuma_Knockback, vel, stun_cnt and ComboCount = 0.
  - Both stun flags = 0.
  - Reset overrides every other input, including mid-PUSH or mid-STUN.
- GamePlaying = 0: all state holds, Akuma_Knockback is registered as 0, HitValid is ignored.
- Hit acceptance, with HitValid = 1 at an edge in any state:
  - v0 = V_x for HitStrength, or v0 = V_x >> 1 when Blocking = 1.
  - stun_cnt = STUN_x, or BLOCK_STUN when Blocking = 1.
  - blk = Blocking.
  - ComboCount = ComboCount + 1, saturating at 15.
  - state = PUSH; vel = v0 - 1; Akuma_Knockback = clamp(v0).
- A hit in PUSH or STUN reloads all of the above, giving a new push. A hit always wins over decay or expiry on the same edge.
- Latency: the hit is sampled at edge N; Akuma_Knockback = clamp(v0) is visible after edge N, so the movement block applies it at edge N+1.
- PUSH, with no hit:
  - If vel > 0: Akuma_Knockback = clamp(vel), vel = vel - 1.
  - If vel == 0: Akuma_Knockback = 0 and state = STUN.
  - Output sequence for v0 = 8 is 8,7,6,5,4,3,2,1.
- STUN, with no hit:
  - Akuma_Knockback = 0.
  - If stun_cnt > 1: stun_cnt decrements.
  - If stun_cnt == 1: state = IDLE and ComboCount = 0.
  - STUN therefore lasts exactly stun_cnt frames. The first STUN frame counts, i.e. the frame whose edge registered Knockback = 0.
- Flags:
  - AkumaHitStun = (state != IDLE) && !blk.
  - AkumaBlockStun = (state != IDLE) && blk.
  - Both flags are registered alongside the state.
- clamp(v):
  - allowed = Bound_X_Max − WALL_OFFSET − AkumaX, computed signed at 32 bits from the AkumaX sampled on the same edge.
  - If allowed <= 0 the result is 0; otherwise min(v, allowed).
  - vel decays unclamped, so time spent pinned against the wall does not shorten the push.
- Akuma_Knockback is never negative; the block never pulls Akuma left.

Decomposition:
- Shared package fighter_pkg holds:
  - typedef kb_state_t enum {IDLE, PUSH, STUN};
  - typedef hit_str_t [1:0];
  - the V_*, STUN_* and BLOCK_STUN constants, which are reused by the Ryu-side twin.
- One natural sub-module is kb_wall_clamp, a combinational clamp(v, AkumaX). Everything else lives in the top block.

Test Plan:
- Heavy unblocked hit, AkumaX = 300 → Knockback 8,7,6,5,4,3,2,1. Then 16 frames of 0 with AkumaHitStun = 1 and ComboCount = 1. Then IDLE with flags and ComboCount = 0.
- Medium blocked hit (v0 = 3) → Knockback 3,2,1. Then 4 frames of 0 with AkumaBlockStun = 1 and AkumaHitStun = 0.
- Heavy hit at AkumaX = 500 (allowed = 4) → first Knockback = 4. At AkumaX = 504 (allowed = 0) → Knockback = 0 while vel still decays to 0.
- Light hit, then a heavy hit on stun frame 3 → immediate reload: Knockback 8 next, ComboCount = 2. Twenty hits in a row → ComboCount holds at 15.
- GamePlaying dropped for 5 frames mid-PUSH at vel = 5 → Knockback = 0 and the state is held. On resume the sequence continues 5,4,…. A HitValid during the freeze is ignored.
- Reset = 0 asserted mid-PUSH → IDLE, Knockback = 0, flags = 0 and ComboCount = 0 after that edge. This holds even when HitValid = 1 on the same edge.
